seg_scan_mux: RTL and testbench
===============================

# seg_scan_mux

Parametrised multi-digit seven-segment scan driver, successor to the fixed 8-state digit chooser. Time-multiplexes `DIGITS` hex digits onto one shared segment bus, with a programmable dwell per digit. Takes two digit banks (selected by `sel`), snapshots the chosen bank once per frame so the display never tears, and adds leading-zero blanking and blink. Sits between the datapath producing BCD/hex values and the board's segment and digit-select pins.

## Interface
Parameters:
- `DIGITS`, 8: number of scanned digits (2..16).
- `DWELL`, 4: clock cycles each digit stays selected (>=1).
- `BLINK_LOG`, 3: blink phase toggles every 2^`BLINK_LOG` frames.

Ports:
- `clkc` in 1: single clock; all state changes on its rising edge.
- `clr` in 1: reset, asynchronous, active-high.
- `sel` in 1: bank select; 0 = `bank0`, 1 = `bank1`.
- `bank0` in 4*`DIGITS`: digit codes; nibble k (bits 4k+3:4k) = digit k; digit 0 = least significant.
- `bank1` in 4*`DIGITS`: second bank, same layout.
- `blank_lz` in 1: enables leading-zero blanking.
- `blink` in 1: enables blinking.
- `outc` out 8: segments {a,b,c,d,e,f,g,dp}, MSB = a, active-high; dp always 0.
- `dig` out `DIGITS`: one-hot digit enable, active-high; bit k = digit k.
- `frame` out 1: one-cycle pulse at each frame boundary.

## Operation
- Decode (hex to `outc`):
  - 0 11111100, 1 01100000, 2 11011010, 3 11110010, 4 01100110, 5 10110110, 6 10111110, 7 11100000
  - 8 11111110, 9 11110110, A 11101110, b 00111110, C 10011100, d 01111010, E 10011110, F 10001110
- Dwell counter `cnt`:
  - Counts 0..`DWELL`-1 and wraps.
  - On wrap, digit index `idx` advances; `idx` counts 0..`DIGITS`-1 and wraps.
- Shadow register:
  - Holds 4*`DIGITS` bits.
  - Loads `sel ? bank1 : bank0` on the first edge after reset release.
  - Also loads on every edge where `idx` wraps from `DIGITS`-1 to 0.
  - `sel`/bank changes between loads have no visible effect.
- Leading-zero blanking, when `blank_lz`=1:
  - A digit is blanked (`outc`=00000000) if it and all more-significant shadow digits are 0.
  - Digit 0 is never blanked, so all-zero shows a single "0".
- Blink:
  - Frame counter has `BLINK_LOG`+1 bits and increments on each frame boundary.
  - Its MSB is the blink phase.
  - When `blink`=1 and phase=1: `outc`=0, `dig` keeps scanning.
  - When `blink`=0: phase is ignored, but the counter keeps running.
- Output registers:
  - `outc` and `dig` are registered and always updated on the same edge.
  - They reflect `idx` and `shadow` as they hold after that edge (decode of next-state values), so `dig` and `outc` are never misaligned.
- `frame` is high for exactly the one cycle following the edge on which the shadow loads at wrap.

## Timing
- Reset values, held while `clr`=1 regardless of clock:
  - `cnt`=0, `idx`=0, shadow=0, frame counter=0.
  - `outc`=00000000, `dig`=0, `frame`=0.
  - Load flag set, so the first post-reset edge loads the shadow.
- First edge after `clr` deasserts:
  - shadow loads.
  - `dig`=…0001.
  - `outc` = decode of digit 0.
  - `frame` stays 0.
- Digit k is selected for exactly `DWELL` cycles; frame length = `DIGITS`*`DWELL` cycles.
- `DWELL`=1: `idx` advances every edge.
- A `sel` change on the wrap edge itself is captured, because the load samples inputs at that edge.
- `clr` asserted mid-frame: all outputs go to reset values immediately (asynchronous). Scanning restarts at digit 0 with a fresh load.

## Test plan
Bench uses `DIGITS`=4, `DWELL`=2, `BLINK_LOG`=0.
1. Release reset with `bank0`=16'h1234, `sel`=0 → two cycles each: `dig`=0001/`outc`=01100110, 0010/11110010, 0100/11011010, 1000/01100000. Then repeats, with `frame`=1 on the cycle after the wrap edge.
2. Set `bank1`=16'hABCD, toggle `sel`=1 while digit 2 is shown → no change for the rest of that frame. Next frame shows d,C,b,A = 01111010, 10011100, 00111110, 11101110.
3. `blank_lz`=1, `bank0`=16'h0070 → digits 3 and 2 show 00000000, digit 1 shows 11100000, digit 0 shows 11111100. With 16'h0000, only digit 0 shows 11111100.
4. `blink`=1 → `outc` alternates: one full frame of digits, one frame all 0. `dig` keeps scanning throughout. Setting `blink`=0 restores digits on the next edge.
5. Assert `clr` mid-dwell between clock edges → `outc`, `dig`, `frame` are 0 before the next edge. After release, scanning restarts at `dig`=0001 with a freshly loaded shadow.
6. Drive all 16 codes through `bank0` digit 0, one per frame → `outc` matches the decode list exactly, and dp is 0 throughout.

Source files
------------

// File: rtl/seg_scan_if.sv
// Bus between the datapath and the seven-segment scan driver. The master side supplies
// the digit banks and display controls. The slave side, the driver, returns the segment
// and digit-select outputs and the frame pulse.
interface seg_scan_if #(
    parameter int unsigned DIGITS = 8
);
    logic                  sel;
    logic [4*DIGITS-1:0]   bank0;
    logic [4*DIGITS-1:0]   bank1;
    logic                  blank_lz;
    logic                  blink;
    logic [7:0]            outc;
    logic [DIGITS-1:0]     dig;
    logic                  frame;

    modport master (
        output sel, bank0, bank1, blank_lz, blink,
        input  outc, dig, frame
    );

    modport slave (
        input  sel, bank0, bank1, blank_lz, blink,
        output outc, dig, frame
    );
endinterface

// File: rtl/seg_scan_mux.sv
// Multi-digit seven-segment scan driver. Each digit is held for DWELL cycles.
// The selected bank is captured once per frame into a shadow register, so the display
// never tears. The driver also provides leading-zero blanking and a blink function.
// The outputs are registered from next-state values, which keeps dig and outc aligned.
module seg_scan_mux #(
    parameter int unsigned DIGITS    = 8,
    parameter int unsigned DWELL     = 4,
    parameter int unsigned BLINK_LOG = 3
) (
    input  logic        clkc,
    input  logic        clr,
    seg_scan_if.slave   bus
);
    localparam int unsigned CntW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int unsigned IdxW = $clog2(DIGITS);
    localparam int unsigned FcW  = BLINK_LOG + 1;
    localparam int unsigned ShW  = 4 * DIGITS;

    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [ShW-1:0]    shadow_q, shadow_d;
    logic [FcW-1:0]    fcnt_q, fcnt_d;
    logic              load_q, load_d;
    logic [7:0]        outc_q, outc_d;
    logic [DIGITS-1:0] dig_q, dig_d;
    logic              frame_q, frame_d;
    logic              wrap;
    logic [DIGITS-1:0] zero_up;

    // Hex digit to active-high segments {a,b,c,d,e,f,g,dp}; dp is always off.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] h);
        logic [7:0] s;
        unique case (h)
            4'h0: s = 8'b11111100;
            4'h1: s = 8'b01100000;
            4'h2: s = 8'b11011010;
            4'h3: s = 8'b11110010;
            4'h4: s = 8'b01100110;
            4'h5: s = 8'b10110110;
            4'h6: s = 8'b10111110;
            4'h7: s = 8'b11100000;
            4'h8: s = 8'b11111110;
            4'h9: s = 8'b11110110;
            4'hA: s = 8'b11101110;
            4'hB: s = 8'b00111110;
            4'hC: s = 8'b10011100;
            4'hD: s = 8'b01111010;
            4'hE: s = 8'b10011110;
            default: s = 8'b10001110;
        endcase
        return s;
    endfunction

    // Dwell and digit counters. The post-reset load edge only primes the shadow, so
    // digit 0 still gets its full dwell.
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        wrap  = 1'b0;
        if (!load_q) begin
            if (cnt_q == CntW'(DWELL - 1)) begin
                cnt_d = '0;
                if (idx_q == IdxW'(DIGITS - 1)) begin
                    idx_d = '0;
                    wrap  = 1'b1;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    // Shadow capture on the first edge after reset and at every frame wrap; frame counter.
    always_comb begin
        shadow_d = shadow_q;
        if (load_q || wrap) begin
            shadow_d = bus.sel ? bus.bank1 : bus.bank0;
        end
        fcnt_d  = wrap ? fcnt_q + FcW'(1) : fcnt_q;
        frame_d = wrap;
        load_d  = 1'b0;
    end

    // zero_up[k] is set when digit k and every more-significant digit of the next shadow are 0.
    always_comb begin
        logic run;
        run     = 1'b1;
        zero_up = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            run        = run && (shadow_d[4*k +: 4] == 4'h0);
            zero_up[k] = run;
        end
    end

    // Segment and digit-select outputs decoded from the post-edge index and shadow.
    always_comb begin
        logic [3:0] nib;
        logic       blanked;
        logic       dark;
        nib     = shadow_d[{idx_d, 2'b00} +: 4];
        blanked = bus.blank_lz && (idx_d != '0) && zero_up[idx_d];
        dark    = bus.blink && fcnt_d[FcW-1];
        outc_d  = (blanked || dark) ? 8'h00 : hex_to_seg(nib);
        dig_d   = DIGITS'(1) << idx_d;
    end

    // State and output registers.
    always_ff @(posedge clkc or posedge clr) begin
        if (clr) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            fcnt_q   <= '0;
            load_q   <= 1'b1;
            outc_q   <= '0;
            dig_q    <= '0;
            frame_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            fcnt_q   <= fcnt_d;
            load_q   <= load_d;
            outc_q   <= outc_d;
            dig_q    <= dig_d;
            frame_q  <= frame_d;
        end
    end

    assign bus.outc  = outc_q;
    assign bus.dig   = dig_q;
    assign bus.frame = frame_q;
endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux with DIGITS=4, DWELL=2 and BLINK_LOG=0.
// Outputs are sampled 1 time unit after each rising edge.
module tb_seg_scan_mux;
    logic clkc;
    logic clr;
    int   n_checks;
    int   n_fail;

    localparam logic [7:0] SegZ = 8'b00000000;
    localparam logic [7:0] Seg0 = 8'b11111100;
    localparam logic [7:0] Seg1 = 8'b01100000;
    localparam logic [7:0] Seg2 = 8'b11011010;
    localparam logic [7:0] Seg3 = 8'b11110010;
    localparam logic [7:0] Seg4 = 8'b01100110;
    localparam logic [7:0] Seg5 = 8'b10110110;
    localparam logic [7:0] Seg7 = 8'b11100000;

    logic [7:0] seg_tab [16];

    seg_scan_if #(.DIGITS(4)) bus_if ();

    seg_scan_mux #(
        .DIGITS    (4),
        .DWELL     (2),
        .BLINK_LOG (0)
    ) dut (
        .clkc (clkc),
        .clr  (clr),
        .bus  (bus_if.slave)
    );

    initial clkc = 1'b0;
    always #5 clkc = ~clkc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clkc);
        #1;
    endtask

    // One digit over its two dwell cycles; f0 is the frame flag expected on the first cycle.
    task automatic show(input int k, input logic [7:0] seg, input logic f0);
        for (int c = 0; c < 2; c++) begin
            tick();
            check($sformatf("dig%0d_c%0d", k, c), 32'(bus_if.dig), 32'd1 << k);
            check($sformatf("seg%0d_c%0d", k, c), 32'(bus_if.outc), 32'(seg));
            check($sformatf("frm%0d_c%0d", k, c), 32'(bus_if.frame), (c == 0) ? 32'(f0) : 32'd0);
        end
    endtask

    task automatic show_frame(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2,
                              input logic [7:0] s3, input logic f);
        show(0, s0, f);
        show(1, s1, 1'b0);
        show(2, s2, 1'b0);
        show(3, s3, 1'b0);
    endtask

    initial begin
        seg_tab = '{8'b11111100, 8'b01100000, 8'b11011010, 8'b11110010,
                    8'b01100110, 8'b10110110, 8'b10111110, 8'b11100000,
                    8'b11111110, 8'b11110110, 8'b11101110, 8'b00111110,
                    8'b10011100, 8'b01111010, 8'b10011110, 8'b10001110};
        n_checks        = 0;
        n_fail          = 0;
        clr             = 1'b1;
        bus_if.sel      = 1'b0;
        bus_if.bank0    = 16'h1234;
        bus_if.bank1    = 16'h0000;
        bus_if.blank_lz = 1'b0;
        bus_if.blink    = 1'b0;

        // Reset state
        #3;
        check("rst_outc", 32'(bus_if.outc), 32'd0);
        check("rst_dig", 32'(bus_if.dig), 32'd0);
        check("rst_frame", 32'(bus_if.frame), 32'd0);
        #9;
        clr = 1'b0;

        // Test 1: basic scan, then a repeat frame with the frame pulse
        show_frame(Seg4, Seg3, Seg2, Seg1, 1'b0);
        show_frame(Seg4, Seg3, Seg2, Seg1, 1'b1);

        // Test 2: the bank switch made mid-frame is invisible until the wrap
        show(0, Seg4, 1'b1);
        show(1, Seg3, 1'b0);
        show(2, Seg2, 1'b0);
        bus_if.bank1 = 16'hABCD;
        bus_if.sel   = 1'b1;
        show(3, Seg1, 1'b0);
        show_frame(8'b01111010, 8'b10011100, 8'b00111110, 8'b11101110, 1'b1);

        // Test 3: leading-zero blanking
        bus_if.sel      = 1'b0;
        bus_if.bank0    = 16'h0070;
        bus_if.blank_lz = 1'b1;
        show_frame(Seg0, Seg7, SegZ, SegZ, 1'b1);
        bus_if.bank0 = 16'h0000;
        show_frame(Seg0, SegZ, SegZ, SegZ, 1'b1);

        // Test 4: blink, the phase flips every frame
        bus_if.blank_lz = 1'b0;
        bus_if.blink    = 1'b1;
        bus_if.bank0    = 16'h1234;
        show_frame(Seg4, Seg3, Seg2, Seg1, 1'b1);
        show_frame(SegZ, SegZ, SegZ, SegZ, 1'b1);
        show_frame(Seg4, Seg3, Seg2, Seg1, 1'b1);
        show(0, SegZ, 1'b1);
        tick();
        check("blink_dark", 32'(bus_if.outc), 32'd0);
        check("blink_dark_dig", 32'(bus_if.dig), 32'b0010);
        bus_if.blink = 1'b0;
        tick();
        check("blink_off", 32'(bus_if.outc), 32'(Seg3));
        check("blink_off_dig", 32'(bus_if.dig), 32'b0010);
        show(2, Seg2, 1'b0);
        show(3, Seg1, 1'b0);

        // Test 5: asynchronous clear mid-dwell
        tick();
        check("pre_clr_seg", 32'(bus_if.outc), 32'(Seg4));
        bus_if.bank0 = 16'h0005;
        #2;
        clr = 1'b1;
        #1;
        check("clr_outc", 32'(bus_if.outc), 32'd0);
        check("clr_dig", 32'(bus_if.dig), 32'd0);
        check("clr_frame", 32'(bus_if.frame), 32'd0);
        clr = 1'b0;
        show_frame(Seg5, Seg0, Seg0, Seg0, 1'b0);

        // Test 6: all 16 codes through digit 0
        for (int c = 0; c < 16; c++) begin
            bus_if.bank0 = {12'h000, 4'(c)};
            show(0, seg_tab[c], 1'b1);
            check($sformatf("dp_%0d", c), 32'(bus_if.outc[0]), 32'd0);
            show(1, Seg0, 1'b0);
            show(2, Seg0, 1'b0);
            show(3, Seg0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
